// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package seg7_pkg;

   localparam int BCD_W = 4;

   typedef logic [6:0] seg_t;

   localparam seg_t           SEG_BLANK = 7'b0;
   localparam logic [BCD_W-1:0] BRI_FULL  = 4'd15;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Host-side control and display-side outputs of the scanned seven-segment driver.
interface seg7_scan_mux_if #(parameter int NUM_DIGITS = 4);
   import seg7_pkg::*;

   logic [BCD_W*NUM_DIGITS-1:0] digits_in;
   logic                        load;
   logic                        blank_lz;
   logic [3:0]                  brightness;
   seg_t                        segments;
   logic [NUM_DIGITS-1:0]       digit_en;
   logic                        frame_done;

   modport master (
      output digits_in, load, blank_lz, brightness,
      input  segments, digit_en, frame_done
   );

   modport slave (
      input  digits_in, load, blank_lz, brightness,
      output segments, digit_en, frame_done
   );

endinterface

// File: rtl/seg7_scan_mux_seg7.sv
// Existing hex-to-seven-segment decoder, {g,f,e,d,c,b,a}, active-high.
module seg7
   import seg7_pkg::*;
(
   input  logic [BCD_W-1:0] code,
   output seg_t             seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_mux.sv
// Double-buffered, PWM-dimmed, time-multiplexed driver for NUM_DIGITS common-cathode digits.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 10_000
)
(
   input logic             clk,
   input logic             reset,
   seg7_scan_mux_if.slave  bus
);

   localparam int CNT_W  = $clog2(SCAN_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DATA_W = BCD_W * NUM_DIGITS;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      scan_cnt;
   logic [IDX_W-1:0]      idx;
   logic [3:0]            pwm_cnt;
   logic [3:0]            bri_q;
   logic [DATA_W-1:0]     pending;
   logic [DATA_W-1:0]     display;
   logic                  pend_valid;
   logic                  slot_end;
   logic                  frame_end;
   logic [BCD_W-1:0]      cur_code;
   seg_t                  cur_seg;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  digit_blank;
   logic                  digit_on;
   logic [NUM_DIGITS-1:0] en_onehot;

   assign slot_end  = (scan_cnt == SLOT_LAST);
   assign frame_end = slot_end && (idx == IDX_LAST);
   assign cur_code  = display[BCD_W*int'(idx) +: BCD_W];

   seg7 u_dec (
      .code (cur_code),
      .seg  (cur_seg)
   );

   // A digit is a leading zero when it and every more-significant digit are zero.
   always_comb begin : lz_mask
      logic zero_run;
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run && (display[BCD_W*i +: BCD_W] == '0);
         lz_blank[i] = bus.blank_lz && zero_run;
      end
   end

   assign digit_blank = lz_blank[idx] || (cur_code > BCD_W'(9));
   assign digit_on    = !digit_blank && (scan_cnt != '0) &&
                        ((bri_q == BRI_FULL) || (pwm_cnt < bri_q));
   assign en_onehot   = NUM_DIGITS'(1) << idx;

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= '0;
         pwm_cnt  <= '0;
         bri_q    <= '0;
      end else begin
         scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
         pwm_cnt  <= slot_end ? '0 : pwm_cnt + 4'd1;
         if (slot_end)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (scan_cnt == '0)
            bri_q <= bus.brightness;
      end
   end

   // Commit reads the pre-edge pending, so a load on the boundary waits a frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         display    <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (frame_end && pend_valid)
            display <= pending;
         if (bus.load) begin
            pending    <= bus.digits_in;
            pend_valid <= 1'b1;
         end else if (frame_end) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.segments   <= SEG_BLANK;
         bus.digit_en   <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.segments   <= digit_blank ? SEG_BLANK : cur_seg;
         bus.digit_en   <= digit_on ? en_onehot : '0;
         bus.frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: per-slot expectations queued by stimulus, checked by a monitor.
module tb_seg7_scan_mux;
   import seg7_pkg::*;

   localparam int ND   = 4;
   localparam int SDIV = 16;

   typedef struct {
      bit         is_rst;
      logic [3:0] en;
      int         on;
      logic [6:0] seg;
      bit         fd;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic rst_q = 1'b1;
   int   st_n = 0;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   int         mon_k = 0;
   logic [3:0] acc_en;
   int         acc_on;
   logic [6:0] first_seg;
   int         seg_changes;
   int         fd_cnt;
   logic       fd_last;

   seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // st_n is the index of the DUT counter state currently held after the last edge.
   always @(posedge clk) begin
      rst_q <= reset;
      st_n  <= reset ? 0 : st_n + 1;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_slot(input logic [3:0] en, input int on, input logic [6:0] seg, input bit fd);
      exp_t e;
      e.is_rst = 1'b0; e.en = en; e.on = on; e.seg = seg; e.fd = fd;
      sb_q.push_back(e);
   endtask

   task automatic push_rst();
      exp_t e;
      e.is_rst = 1'b1; e.en = '0; e.on = 0; e.seg = '0; e.fd = 1'b0;
      sb_q.push_back(e);
   endtask

   // segs = {digit3, digit2, digit1, digit0}; lit marks digits whose enable should fire.
   task automatic push_frame(input logic [27:0] segs, input logic [3:0] lit, input int on);
      for (int d = 0; d < ND; d++)
         push_slot(lit[d] ? 4'(1 << d) : 4'b0, lit[d] ? on : 0, segs[7*d +: 7], d == ND - 1);
   endtask

   task automatic wait_state(input int t);
      int guard = 0;
      while (st_n != t && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (st_n != t) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL wait_state: got %0d, expected %0d", st_n, t);
      end
   endtask

   task automatic apply_stimulus(input logic [15:0] data);
      bus.digits_in = data;
      bus.load      = 1'b1;
      @(negedge clk);
      bus.load      = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_q) begin
         mon_k = 0;
         if (sb_q.size() == 0) begin
            check_output("sb_rst_empty", 32'd0, 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_output("rst_kind", e.is_rst, 1);
            check_output("rst_segments", bus.segments, 0);
            check_output("rst_digit_en", bus.digit_en, 0);
            check_output("rst_frame_done", bus.frame_done, 0);
         end
      end else begin
         int pos;
         pos = mon_k % SDIV;
         if (pos == 0) begin
            acc_en = '0; acc_on = 0; first_seg = bus.segments;
            seg_changes = 0; fd_cnt = 0; fd_last = 1'b0;
         end
         acc_en |= bus.digit_en;
         if (bus.digit_en != '0) acc_on++;
         if (bus.segments !== first_seg) seg_changes++;
         if (bus.frame_done) fd_cnt++;
         if (pos == SDIV - 1) begin
            fd_last = bus.frame_done;
            if (sb_q.size() == 0) begin
               check_output("sb_empty", 32'd0, 32'd1);
            end else begin
               exp_t e;
               int   s;
               s = mon_k / SDIV;
               e = sb_q.pop_front();
               check_output($sformatf("s%0d_kind", s), e.is_rst, 0);
               check_output($sformatf("s%0d_digit_en", s), acc_en, e.en);
               check_output($sformatf("s%0d_on_cycles", s), acc_on, e.on);
               check_output($sformatf("s%0d_segments", s), first_seg, e.seg);
               check_output($sformatf("s%0d_seg_stable", s), seg_changes, 0);
               check_output($sformatf("s%0d_fd_count", s), fd_cnt, e.fd);
               check_output($sformatf("s%0d_fd_last", s), fd_last, e.fd);
            end
         end
         mon_k++;
      end
   end

   initial begin
      reset          = 1'b1;
      bus.digits_in  = '0;
      bus.load       = 1'b0;
      bus.blank_lz   = 1'b0;
      bus.brightness = 4'd15;
      push_rst();
      push_rst();
      push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 15);
      push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 15);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Load mid-frame 1: invisible until frame 2.
      wait_state(84);
      apply_stimulus(16'h1234);
      push_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b1111, 15);

      // Two loads in frame 2, last wins; leading zeros blanked in frame 3.
      wait_state(133);
      bus.blank_lz = 1'b1;
      wait_state(138);
      apply_stimulus(16'h0007);
      wait_state(168);
      apply_stimulus(16'h0042);
      push_frame({7'h00, 7'h00, 7'h66, 7'h5B}, 4'b0011, 15);

      wait_state(245);
      bus.brightness = 4'd4;
      push_frame({7'h00, 7'h00, 7'h66, 7'h5B}, 4'b0011, 3);

      wait_state(309);
      bus.brightness = 4'd0;
      push_frame({7'h3F, 7'h3F, 7'h66, 7'h5B}, 4'b0000, 0);

      // Non-BCD digit 1 blanks its own slot only.
      wait_state(330);
      bus.blank_lz = 1'b0;
      apply_stimulus(16'h00A0);
      wait_state(373);
      bus.brightness = 4'd15;
      push_frame({7'h3F, 7'h3F, 7'h00, 7'h3F}, 4'b1101, 15);

      // Pending load is dropped by a reset in the middle of slot 2.
      wait_state(453);
      apply_stimulus(16'h5555);
      push_slot(4'b0001, 15, 7'h3F, 1'b0);
      push_slot(4'b0000, 0, 7'h00, 1'b0);
      push_rst();
      push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 15);
      push_frame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111, 15);
      wait_state(486);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 400 && sb_q.size() != 0; i++)
         @(negedge clk);
      check_output("drain", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
